// File: rtl/ecc_read_arbiter_if.sv
// Requester, memory and status bundle of the ECC read arbiter.
interface ecc_read_arbiter_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned CNT_W     = 16
);
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS-1:0]        gnt;
  logic                        mem_rd_en;
  logic [ADDR_W-1:0]           mem_addr;
  logic [11:0]                 mem_dout;
  logic [NUM_PORTS-1:0]        rd_valid;
  logic [7:0]                  rd_data;
  logic                        err_corrected;
  logic                        err_uncorrectable;
  logic [3:0]                  err_syndrome;
  logic [CNT_W-1:0]            err_count;
  logic                        clr_count;

  // Requesters plus memory model side
  modport master (
    output req, addr, clr_count, mem_dout,
    input  gnt, mem_rd_en, mem_addr, rd_valid, rd_data,
           err_corrected, err_uncorrectable, err_syndrome, err_count
  );

  // Arbiter side
  modport slave (
    input  req, addr, clr_count, mem_dout,
    output gnt, mem_rd_en, mem_addr, rd_valid, rd_data,
           err_corrected, err_uncorrectable, err_syndrome, err_count
  );
endinterface

// File: rtl/ecc_read_arbiter.sv
// Round-robin read scheduler sharing one Hamming(12,8) protected memory read
// port; tracks in-flight reads with a fixed-latency tag pipeline and returns
// decoded data plus correction status to the originating port.
module ecc_read_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned CNT_W      = 16
) (
  input logic clk,
  input logic rst,
  ecc_read_arbiter_if.slave bus
);

  localparam int unsigned IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned CW_W   = 12;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SYN_W  = 4;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] port;
  } tag_t;

  // Registered state
  logic [NUM_PORTS-1:0]       gnt_q, gnt_d;
  logic                       mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0]          mem_addr_q, mem_addr_d;
  logic [IDX_W-1:0]           gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]           last_q, last_d;
  logic [NUM_PORTS-1:0]       outstanding_q, outstanding_d;
  tag_t [RD_LATENCY-1:0]      tag_q, tag_d;
  logic [NUM_PORTS-1:0]       rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]          rd_data_q, rd_data_d;
  logic                       err_corrected_q, err_corrected_d;
  logic                       err_uncorrectable_q, err_uncorrectable_d;
  logic [SYN_W-1:0]           err_syndrome_q, err_syndrome_d;
  logic [CNT_W-1:0]           err_count_q, err_count_d;

  // Combinational helpers
  logic [NUM_PORTS-1:0]       busy_c;
  logic [NUM_PORTS-1:0]       elig_c;
  logic [PTR_W-1:0]           cand_c;
  logic                       found_c;
  logic [CW_W-1:0]            cw_c;
  logic [CW_W-1:0]            cw_fix_c;
  logic [SYN_W-1:0]           syn_c;
  logic                       corr_c;
  logic                       unc_c;
  logic [DATA_W-1:0]          data_c;
  tag_t                       head_c;
  logic                       unused_cw_c;

  // Round-robin pick among ports with a request and no read in flight
  always_comb begin
    busy_c        = outstanding_q & ~rd_valid_q;
    elig_c        = bus.req & ~busy_c;
    cand_c        = '0;
    found_c       = 1'b0;
    gnt_d         = '0;
    gnt_idx_d     = gnt_idx_q;
    mem_rd_en_d   = 1'b0;
    mem_addr_d    = '0;
    last_d        = last_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand_c = PTR_W'(last_q) + PTR_W'(1) + PTR_W'(i);
      if (cand_c >= PTR_W'(NUM_PORTS)) cand_c = cand_c - PTR_W'(NUM_PORTS);
      if (!found_c && elig_c[cand_c[IDX_W-1:0]]) begin
        found_c                    = 1'b1;
        gnt_d[cand_c[IDX_W-1:0]]   = 1'b1;
        gnt_idx_d                  = cand_c[IDX_W-1:0];
        last_d                     = cand_c[IDX_W-1:0];
        mem_rd_en_d                = 1'b1;
      end
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (gnt_d[p]) mem_addr_d = bus.addr[p*ADDR_W +: ADDR_W];
    end
    // A grant in the same cycle as the return re-arms the bit
    outstanding_d = busy_c | gnt_d;
  end

  // Tag shift pipeline aligned with memory read latency
  always_comb begin
    tag_d          = tag_q;
    tag_d[0].valid = mem_rd_en_q;
    tag_d[0].port  = gnt_idx_q;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Hamming syndrome, single-bit correction and data extraction
  always_comb begin
    cw_c     = bus.mem_dout;
    syn_c[0] = ^{cw_c[10], cw_c[8], cw_c[6], cw_c[4], cw_c[2], cw_c[0]};
    syn_c[1] = ^{cw_c[10], cw_c[9], cw_c[6], cw_c[5], cw_c[2], cw_c[1]};
    syn_c[2] = ^{cw_c[11], cw_c[6], cw_c[5], cw_c[4], cw_c[3]};
    syn_c[3] = ^{cw_c[11], cw_c[10], cw_c[9], cw_c[8], cw_c[7]};
    cw_fix_c = cw_c;
    corr_c   = 1'b0;
    unc_c    = 1'b0;
    if (syn_c >= SYN_W'(13)) begin
      unc_c = 1'b1;
    end else if (syn_c != '0) begin
      corr_c                         = 1'b1;
      cw_fix_c[syn_c - SYN_W'(1)]    = ~cw_c[syn_c - SYN_W'(1)];
    end
    data_c = {cw_fix_c[11:8], cw_fix_c[6:4], cw_fix_c[2]};
  end

  // Parity positions carry no data
  assign unused_cw_c = ^{cw_fix_c[7], cw_fix_c[3], cw_fix_c[1:0]};

  // Return path outputs and saturating correction counter
  always_comb begin
    head_c              = tag_q[RD_LATENCY-1];
    rd_valid_d          = '0;
    rd_data_d           = rd_data_q;
    err_corrected_d     = 1'b0;
    err_uncorrectable_d = 1'b0;
    err_syndrome_d      = '0;
    err_count_d         = err_count_q;
    if (head_c.valid) begin
      rd_valid_d[head_c.port] = 1'b1;
      rd_data_d               = data_c;
      err_corrected_d         = corr_c;
      err_uncorrectable_d     = unc_c;
      err_syndrome_d          = syn_c;
      if (corr_c && (err_count_q != {CNT_W{1'b1}})) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end
    if (bus.clr_count) err_count_d = '0;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q               <= '0;
      mem_rd_en_q         <= 1'b0;
      mem_addr_q          <= '0;
      gnt_idx_q           <= '0;
      last_q              <= IDX_W'(NUM_PORTS - 1);
      outstanding_q       <= '0;
      tag_q               <= '0;
      rd_valid_q          <= '0;
      rd_data_q           <= '0;
      err_corrected_q     <= 1'b0;
      err_uncorrectable_q <= 1'b0;
      err_syndrome_q      <= '0;
      err_count_q         <= '0;
    end else begin
      gnt_q               <= gnt_d;
      mem_rd_en_q         <= mem_rd_en_d;
      mem_addr_q          <= mem_addr_d;
      gnt_idx_q           <= gnt_idx_d;
      last_q              <= last_d;
      outstanding_q       <= outstanding_d;
      tag_q               <= tag_d;
      rd_valid_q          <= rd_valid_d;
      rd_data_q           <= rd_data_d;
      err_corrected_q     <= err_corrected_d;
      err_uncorrectable_q <= err_uncorrectable_d;
      err_syndrome_q      <= err_syndrome_d;
      err_count_q         <= err_count_d;
    end
  end

  assign bus.gnt               = gnt_q;
  assign bus.mem_rd_en         = mem_rd_en_q;
  assign bus.mem_addr          = mem_addr_q;
  assign bus.rd_valid          = rd_valid_q;
  assign bus.rd_data           = rd_data_q;
  assign bus.err_corrected     = err_corrected_q;
  assign bus.err_uncorrectable = err_uncorrectable_q;
  assign bus.err_syndrome      = err_syndrome_q;
  assign bus.err_count         = err_count_q;

endmodule

// File: tb/tb_ecc_read_arbiter.sv
// Scoreboard bench for ecc_read_arbiter: main instance plus a narrow-counter
// instance for saturation and clear-priority checks.
module tb_ecc_read_arbiter;

  localparam int unsigned NP  = 4;
  localparam int unsigned AW  = 8;
  localparam int unsigned LAT = 2;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
    logic [3:0] syn;
    logic       corr;
    logic       unc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ecc_read_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .CNT_W(16)) bus ();
  ecc_read_arbiter_if #(.NUM_PORTS(2), .ADDR_W(AW), .CNT_W(2))   bus2 ();

  ecc_read_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .RD_LATENCY(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  ecc_read_arbiter #(.NUM_PORTS(2), .ADDR_W(AW), .RD_LATENCY(LAT), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decoder: syndrome is XOR of 1-based positions of set bits
  function automatic exp_t model(input logic [1:0] p, input logic [11:0] cw);
    exp_t       e;
    logic [3:0] s;
    logic [11:0] c;
    s = 4'd0;
    c = cw;
    for (int i = 0; i < 12; i++) if (cw[i]) s ^= 4'(i + 1);
    e.port = p;
    e.syn  = s;
    e.unc  = (s >= 4'd13);
    e.corr = (s != 4'd0) && !e.unc;
    if (e.corr) c[s - 4'd1] = ~c[s - 4'd1];
    e.data = {c[11:8], c[6:4], c[2]};
    return e;
  endfunction

  // Memory model with fixed read latency
  logic [11:0]   mem_arr [256];
  logic [AW-1:0] apipe   [LAT];
  always @(posedge clk) begin
    apipe[0] <= bus.mem_addr;
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign bus.mem_dout  = mem_arr[apipe[LAT-1]];
  assign bus2.mem_dout = 12'hA07;
  assign bus2.addr     = '0;

  logic rst_seen, clr2_seen;
  always @(posedge clk) begin
    rst_seen  <= rst;
    clr2_seen <= bus2.clr_count;
  end

  exp_t        sb [$];
  logic [NP-1:0] busy;
  logic [15:0] cnt;
  int          exp_rr;
  logic        fair_mode = 1'b0;

  // Scoreboard monitor for the main instance
  always @(negedge clk) begin
    exp_t e;
    int   p;
    if (rst_seen !== 1'b0) begin
      sb.delete();
      busy   = '0;
      cnt    = '0;
      exp_rr = 0;
    end else begin
      if (bus.rd_valid != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_rd_valid", 64'(bus.rd_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          if (e.corr && cnt != 16'hFFFF) cnt = cnt + 16'd1;
          check("ret_port",  64'(bus.rd_valid), 64'(4'(1) << e.port));
          check("ret_data",  64'(bus.rd_data), 64'(e.data));
          check("ret_syn",   64'(bus.err_syndrome), 64'(e.syn));
          check("ret_corr",  64'(bus.err_corrected), 64'(e.corr));
          check("ret_unc",   64'(bus.err_uncorrectable), 64'(e.unc));
          busy[e.port] = 1'b0;
        end
      end else begin
        check("idle_err_flags",
              64'({bus.err_corrected, bus.err_uncorrectable, bus.err_syndrome}), 64'd0);
      end
      check("err_count", 64'(bus.err_count), 64'(cnt));
      if (bus.gnt != '0) begin
        p = 0;
        for (int i = 0; i < NP; i++) if (bus.gnt[i]) p = i;
        check("gnt_onehot", 64'($onehot(bus.gnt)), 64'd1);
        check("gnt_rd_en",  64'(bus.mem_rd_en), 64'd1);
        check("gnt_addr",   64'(bus.mem_addr), 64'(bus.addr[p*AW +: AW]));
        check("gnt_not_busy", 64'(busy[p]), 64'd0);
        if (fair_mode) check("rr_order", 64'(p), 64'(exp_rr));
        exp_rr  = (p + 1) % NP;
        busy[p] = 1'b1;
        sb.push_back(model(2'(p), mem_arr[bus.addr[p*AW +: AW]]));
      end else begin
        check("idle_rd_en", 64'(bus.mem_rd_en), 64'd0);
      end
    end
  end

  // Narrow-counter instance: every return is a corrected one
  logic [1:0] cnt2;
  int         n_ret2 = 0;
  always @(negedge clk) begin
    exp_t e2;
    if (rst_seen !== 1'b0) begin
      cnt2 = '0;
    end else begin
      e2 = model(2'd0, 12'hA07);
      if (clr2_seen) cnt2 = '0;
      else if (bus2.rd_valid[0] && e2.corr && cnt2 != 2'd3) cnt2 = cnt2 + 2'd1;
      if (bus2.rd_valid != '0) begin
        n_ret2++;
        check("c2_port",  64'(bus2.rd_valid), 64'd1);
        check("c2_corr",  64'(bus2.err_corrected), 64'(e2.corr));
        check("c2_count", 64'(bus2.err_count), 64'(cnt2));
      end
    end
  end

  task automatic wait_gnt(input int max_cyc);
    int t;
    t = 0;
    while (bus.gnt == '0 && t < max_cyc) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic single_read(input int p, input logic [7:0] a, input logic [11:0] cw,
                             input logic [7:0] ed, input logic [3:0] es, input logic ec,
                             input logic eu, input logic [15:0] ecnt);
    mem_arr[a]          = cw;
    bus.addr[p*AW +: AW] = a;
    bus.req[p]          = 1'b1;
    @(negedge clk);
    wait_gnt(20);
    check("sr_gnt",      64'(bus.gnt), 64'(4'(1) << p));
    check("sr_mem_addr", 64'(bus.mem_addr), 64'(a));
    bus.req[p] = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    check("sr_rd_valid", 64'(bus.rd_valid), 64'(4'(1) << p));
    check("sr_rd_data",  64'(bus.rd_data), 64'(ed));
    check("sr_syndrome", 64'(bus.err_syndrome), 64'(es));
    check("sr_corr",     64'(bus.err_corrected), 64'(ec));
    check("sr_unc",      64'(bus.err_uncorrectable), 64'(eu));
    check("sr_count",    64'(bus.err_count), 64'(ecnt));
    @(negedge clk);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.gnt, bus.mem_rd_en, bus.mem_addr, bus.rd_valid, bus.rd_data,
                bus.err_corrected, bus.err_uncorrectable, bus.err_syndrome, bus.err_count});
  endfunction

  initial begin
    logic seen2;
    int   t;
    for (int i = 0; i < 256; i++) mem_arr[i] = 12'h000;
    bus.req        = '0;
    bus.addr       = '0;
    bus.clr_count  = 1'b0;
    bus2.req       = '0;
    bus2.clr_count = 1'b0;
    rst            = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed returns: clean, single-bit error, double-bit error
    single_read(1, 8'h10, 12'hA27, 8'hA5, 4'd0,  1'b0, 1'b0, 16'd0);
    single_read(1, 8'h20, 12'hA07, 8'hA5, 4'd6,  1'b1, 1'b0, 16'd1);
    single_read(3, 8'h30, 12'h223, 8'h24, 4'd15, 1'b0, 1'b1, 16'd1);

    // All ports requesting: strict rotation, random codewords
    for (int p = 0; p < NP; p++) begin
      mem_arr[8'h40 + p]   = 12'($urandom);
      bus.addr[p*AW +: AW] = 8'(8'h40 + p);
    end
    fair_mode = 1'b1;
    bus.req   = '1;
    repeat (20) @(negedge clk);
    bus.req   = '0;
    fair_mode = 1'b0;
    drain();

    // Reset one cycle after a grant drops the in-flight read
    bus.addr[2*AW +: AW] = 8'h50;
    mem_arr[8'h50]       = 12'hA27;
    bus.req              = 4'b0100;
    @(negedge clk);
    wait_gnt(20);
    check("mid_gnt2", 64'(bus.gnt), 64'h4);
    bus.req = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_reset_outputs", all_outs(), 64'd0);
    seen2 = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rd_valid[2]) seen2 = 1'b1;
    end
    check("mid_no_rd_valid2", 64'(seen2), 64'd0);
    bus.addr[0*AW +: AW] = 8'h60;
    bus.addr[3*AW +: AW] = 8'h63;
    bus.req              = 4'b1001;
    @(negedge clk);
    wait_gnt(20);
    check("post_reset_gnt", 64'(bus.gnt), 64'h1);
    bus.req = '0;
    drain();

    // Narrow counter: saturation at 3
    bus2.req = 2'b01;
    t = 0;
    while (n_ret2 < 5 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("c2_returns_seen", 64'(n_ret2 >= 5), 64'd1);
    bus2.req = '0;
    repeat (8) @(negedge clk);
    check("c2_saturated", 64'(bus2.err_count), 64'd3);

    // Clear coinciding with a corrected return: clear wins
    bus2.req = 2'b01;
    t = 0;
    @(negedge clk);
    while (bus2.gnt == '0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("c2_gnt", 64'(bus2.gnt), 64'd1);
    bus2.req = '0;
    @(negedge clk);
    @(negedge clk);
    bus2.clr_count = 1'b1;
    @(negedge clk);
    bus2.clr_count = 1'b0;
    check("c2_clr_rd_valid", 64'(bus2.rd_valid), 64'd1);
    check("c2_clr_corr",     64'(bus2.err_corrected), 64'd1);
    check("c2_clr_count",    64'(bus2.err_count), 64'd0);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
